// File: rtl/simd_sequencer.sv
// Program sequencer: walks instruction slots and issues one datapath operation
// per data chunk in each instruction's [F..L] range over a valid/ready handshake.
module simd_sequencer #(
   parameter int CHUNKS    = 16,
   parameter int INS_DEPTH = 256
) (
   input  logic                         CLK,
   input  logic                         RSTN,
   input  logic                         START,
   input  logic                         ABORT,
   input  logic [31:0]                  INS_IN,
   output logic [$clog2(INS_DEPTH)-1:0] SEQ_INS,
   output logic [$clog2(CHUNKS)-1:0]    SEQ_DATC,
   output logic                         OP_VALID,
   input  logic                         OP_READY,
   output logic [7:0]                   OP_CODE,
   output logic                         OP_LAST,
   output logic                         BUSY,
   output logic                         DONE,
   output logic                         ERR
);
   localparam int DW = $clog2(CHUNKS);
   localparam int IW = $clog2(INS_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;
   localparam logic [1:0] FIN   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] ins_q, ins_d;
   logic [DW-1:0] datc_q, datc_d;
   logic [DW-1:0] last_q, last_d;
   logic [7:0]    code_q, code_d;
   logic          err_q, err_d;

   logic [7:0]    ins_op;
   logic [DW-1:0] ins_f, ins_l;
   logic          unused_ins_bits;

   assign ins_op          = INS_IN[31:24];
   assign ins_f           = DW'(INS_IN[23:20]);
   assign ins_l           = DW'(INS_IN[19:16]);
   assign unused_ins_bits = ^INS_IN[15:0];

   always_comb begin
      state_d = state_q;
      ins_d   = ins_q;
      datc_d  = datc_q;
      last_d  = last_q;
      code_d  = code_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               state_d = FETCH;
               ins_d   = '0;
               err_d   = 1'b0;
            end
         end
         FETCH: begin
            if (ABORT) begin
               state_d = IDLE;
            end else if (ins_op == 8'h00) begin
               state_d = FIN;
            end else if (ins_f > ins_l) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               code_d  = ins_op;
               datc_d  = ins_f;
               last_d  = ins_l;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // ABORT wins over a same-cycle handshake, so no transfer happens
            if (ABORT) begin
               state_d = IDLE;
            end else if (OP_READY) begin
               if (datc_q < last_q) begin
                  datc_d = datc_q + 1'b1;
               end else if (ins_q == IW'(INS_DEPTH - 1)) begin
                  state_d = FIN;
               end else begin
                  ins_d   = ins_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q <= IDLE;
         ins_q   <= '0;
         datc_q  <= '0;
         last_q  <= '0;
         code_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ins_q   <= ins_d;
         datc_q  <= datc_d;
         last_q  <= last_d;
         code_q  <= code_d;
         err_q   <= err_d;
      end
   end

   assign SEQ_INS  = ins_q;
   assign SEQ_DATC = datc_q;
   assign OP_CODE  = code_q;
   assign ERR      = err_q;
   assign OP_VALID = (state_q == ISSUE);
   assign OP_LAST  = OP_VALID && (datc_q == last_q);
   assign BUSY     = (state_q == FETCH) || (state_q == ISSUE);
   assign DONE     = (state_q == FIN);
endmodule

// File: tb/tb_simd_sequencer.sv
// Directed bench for simd_sequencer: a table of per-cycle vectors plus
// hand-written sequences for the full 256-slot program and mid-issue reset.
module tb_simd_sequencer;
   logic        clk = 1'b0;
   logic        rstn, start, abort, op_ready;
   logic [31:0] ins_in;
   logic [7:0]  seq_ins;
   logic [3:0]  seq_datc;
   logic        op_valid, op_last, busy, done, err;
   logic [7:0]  op_code;

   logic [31:0] mem [256];
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;
   assign ins_in = mem[seq_ins];

   simd_sequencer #(.CHUNKS(16), .INS_DEPTH(256)) dut (
      .CLK(clk), .RSTN(rstn), .START(start), .ABORT(abort), .INS_IN(ins_in),
      .SEQ_INS(seq_ins), .SEQ_DATC(seq_datc), .OP_VALID(op_valid),
      .OP_READY(op_ready), .OP_CODE(op_code), .OP_LAST(op_last),
      .BUSY(busy), .DONE(done), .ERR(err)
   );

   typedef struct {
      logic [31:0] ins0;
      logic        s, a, r;
      logic        v, b, d, e, l;
      logic [3:0]  datc;
      logic [7:0]  code;
      logic [7:0]  ins;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic [31:0] ins0, input logic s, a, r,
                               input logic v, b, d, e, l, input logic [3:0] datc,
                               input logic [7:0] code, input logic [7:0] ins);
      vec_t t;
      t.ins0 = ins0; t.s = s; t.a = a; t.r = r;
      t.v = v; t.b = b; t.d = d; t.e = e; t.l = l;
      t.datc = datc; t.code = code; t.ins = ins;
      return t;
   endfunction

   task automatic check(input string nm, input bit ok, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic a, input logic r);
      @(negedge clk);
      start = s; abort = a; op_ready = r;
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] P = 32'h1124_0000;
   localparam logic [31:0] E = 32'h2251_0000;

   initial begin
      logic [63:0] act, exp;
      int          n;
      bit          seen_done;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      rstn = 1'b0; start = 1'b1; abort = 1'b0; op_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      act = {55'd0, op_valid, busy, done, err, op_last, seq_ins != 0, seq_datc != 0, op_code != 0};
      check("reset_state", act == 64'd0, act, 64'd0);
      @(negedge clk);
      rstn = 1'b1; start = 1'b0;

      // chunks 2..4 back to back, then chunk-3 stall, bad range, abort, START while busy
      tv.push_back(mk(P,1,0,0, 0,1,0,0,0, 0,8'h00,0));
      tv.push_back(mk(P,0,0,1, 1,1,0,0,0, 2,8'h11,0));
      tv.push_back(mk(P,0,0,1, 1,1,0,0,0, 3,8'h11,0));
      tv.push_back(mk(P,0,0,1, 1,1,0,0,1, 4,8'h11,0));
      tv.push_back(mk(P,0,0,1, 0,1,0,0,0, 0,8'h00,1));
      tv.push_back(mk(P,0,0,1, 0,0,1,0,0, 0,8'h00,1));
      tv.push_back(mk(P,0,0,1, 0,0,0,0,0, 0,8'h00,1));
      tv.push_back(mk(P,1,0,0, 0,1,0,0,0, 0,8'h00,0));
      tv.push_back(mk(P,0,0,1, 1,1,0,0,0, 2,8'h11,0));
      tv.push_back(mk(P,0,0,1, 1,1,0,0,0, 3,8'h11,0));
      tv.push_back(mk(P,0,0,0, 1,1,0,0,0, 3,8'h11,0));
      tv.push_back(mk(P,0,0,0, 1,1,0,0,0, 3,8'h11,0));
      tv.push_back(mk(P,0,0,0, 1,1,0,0,0, 3,8'h11,0));
      tv.push_back(mk(P,0,0,1, 1,1,0,0,1, 4,8'h11,0));
      tv.push_back(mk(P,0,0,1, 0,1,0,0,0, 0,8'h00,1));
      tv.push_back(mk(P,0,0,0, 0,0,1,0,0, 0,8'h00,1));
      tv.push_back(mk(P,0,0,0, 0,0,0,0,0, 0,8'h00,1));
      tv.push_back(mk(E,1,0,0, 0,1,0,0,0, 0,8'h00,0));
      tv.push_back(mk(E,0,0,1, 0,0,1,1,0, 0,8'h00,0));
      tv.push_back(mk(E,0,0,0, 0,0,0,1,0, 0,8'h00,0));
      tv.push_back(mk(P,1,0,0, 0,1,0,0,0, 0,8'h00,0));
      tv.push_back(mk(P,0,0,0, 1,1,0,0,0, 2,8'h11,0));
      tv.push_back(mk(P,0,0,1, 1,1,0,0,0, 3,8'h11,0));
      tv.push_back(mk(P,0,1,1, 0,0,0,0,0, 0,8'h00,0));
      tv.push_back(mk(P,0,1,0, 0,0,0,0,0, 0,8'h00,0));
      tv.push_back(mk(P,1,0,0, 0,1,0,0,0, 0,8'h00,0));
      tv.push_back(mk(P,1,0,0, 1,1,0,0,0, 2,8'h11,0));
      tv.push_back(mk(P,1,0,0, 1,1,0,0,0, 2,8'h11,0));
      tv.push_back(mk(P,0,1,0, 0,0,0,0,0, 0,8'h00,0));

      foreach (tv[i]) begin
         mem[0] = tv[i].ins0;
         step(tv[i].s, tv[i].a, tv[i].r);
         act = {op_valid, busy, done, err, op_last, seq_ins,
                tv[i].v ? seq_datc : 4'd0, tv[i].v ? op_code : 8'd0};
         exp = {tv[i].v, tv[i].b, tv[i].d, tv[i].e, tv[i].l, tv[i].ins,
                tv[i].v ? tv[i].datc : 4'd0, tv[i].v ? tv[i].code : 8'd0};
         check($sformatf("vec%0d", i), act == exp, act, exp);
      end

      // every slot a single-chunk op: 256 transfers, no wrap past the last slot
      for (int i = 0; i < 256; i++) mem[i] = 32'h3300_0000;
      step(1, 0, 1);
      n = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 1200 && !seen_done; c++) begin
         step(0, 0, 1);
         if (op_valid) begin
            check("full_slot_idx", seq_ins == n[7:0], 64'(seq_ins), 64'(n[7:0]));
            n++;
         end
         if (done) seen_done = 1'b1;
      end
      check("full_done_seen", seen_done, 64'(seen_done), 64'd1);
      check("full_xfer_count", n == 256, 64'(n), 64'd256);
      check("full_end_slot", seq_ins == 8'd255, 64'(seq_ins), 64'd255);
      for (int c = 0; c < 4; c++) begin
         step(0, 0, 1);
         check("full_no_wrap", !op_valid && !busy, {62'd0, op_valid, busy}, 64'd0);
      end

      // reset while issuing slot 5 with a nonzero chunk
      mem[5] = 32'h4437_0000;
      step(1, 0, 1);
      n = 0;
      while (!(op_valid && seq_ins == 8'd5) && n < 100) begin
         step(0, 0, 1);
         n++;
      end
      check("rst_reach_slot5", op_valid && seq_ins == 8'd5 && seq_datc == 4'd3 && op_code == 8'h44,
            {seq_ins, seq_datc, op_code}, {8'd5, 4'd3, 8'h44});
      @(negedge clk);
      rstn = 1'b0; start = 1'b1; abort = 1'b1; op_ready = 1'b1;
      @(posedge clk);
      #1;
      act = {op_valid, busy, done, err, op_last, seq_ins, seq_datc, op_code};
      check("rst_mid_issue", act == 64'd0, act, 64'd0);
      @(negedge clk);
      rstn = 1'b1; start = 1'b0; abort = 1'b0;
      @(posedge clk);
      #1;
      check("rst_no_done", !done && !busy, {62'd0, done, busy}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
